// File: rtl/sha_state_accum.sv
// -----------------------------------------------------------------------------
// sha_state_accum
//   SHA-256 chaining-state accumulator for a double-SHA miner. It holds the
//   WORDS-wide chaining state and adds compressor results to it, word by word,
//   across three phases: header block 1, header block 2 and the second hash.
//   The state after block 1 is cached as a midstate, so a nonce sweep can
//   restart at block 2 without recomputing block 1.
//
//   Optional feature (macro MIDSTATE_LOAD_EN): adds mid_load / mid_in so the
//   host can load a precomputed midstate while the block is in IDLE or DONE.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           begin a new job: full three-phase hash from IV
//   sweep           new nonce: restart at phase 2 from the cached midstate
//   f_valid/f_ready compressor result handshake (f, word0 in LSBs)
//   chain           chaining state fed to the compressor for the current phase
//   inner           first-hash digest (message for phase 3)
//   digest          final double-SHA digest, held while digest_valid is high
//   digest_ready    consumer takes digest
//   phase           0 idle, 1/2/3 awaiting block 1/2/3
//   mid_ok          midstate cache valid
//   sweep_err       one-cycle pulse: sweep issued with no valid midstate
//   mid_load,mid_in (MIDSTATE_LOAD_EN only) host midstate load
// -----------------------------------------------------------------------------
module sha_state_accum #(
   parameter int unsigned          W     = 32,
   parameter int unsigned          WORDS = 8,
   // word0 sits in the LSBs; word5/word6 follow the miner's packing order
   parameter logic [WORDS*W-1:0]   IV    = {32'h5be0cd19, 32'h9b05688c,
                                            32'h1f83d9ab, 32'h510e527f,
                                            32'ha54ff53a, 32'h3c6ef372,
                                            32'hbb67ae85, 32'h6a09e667}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 sweep,
   input  logic                 f_valid,
   output logic                 f_ready,
   input  logic [WORDS*W-1:0]   f,
   output logic [WORDS*W-1:0]   chain,
   output logic [WORDS*W-1:0]   inner,
   output logic [WORDS*W-1:0]   digest,
   output logic                 digest_valid,
   input  logic                 digest_ready,
   output logic [1:0]           phase,
   output logic                 mid_ok,
   output logic                 sweep_err
`ifdef MIDSTATE_LOAD_EN
   ,
   input  logic                 mid_load,
   input  logic [WORDS*W-1:0]   mid_in
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_B1, S_B2, S_B3, S_DONE} state_e;

   state_e               state_q;
   logic [WORDS*W-1:0]   chain_q, mid_q, inner_q, digest_q;
   logic                 mid_ok_q, digest_valid_q, sweep_err_q;
   logic [WORDS*W-1:0]   sum_d;
   logic                 mid_load_w;
   logic [WORDS*W-1:0]   mid_in_w;
   logic                 rest_w;   // IDLE or DONE: the states that accept sweep / mid_load

`ifdef MIDSTATE_LOAD_EN
   assign mid_load_w = mid_load;
   assign mid_in_w   = mid_in;
`else
   assign mid_load_w = 1'b0;
   assign mid_in_w   = '0;
`endif

   assign rest_w = (state_q == S_IDLE) || (state_q == S_DONE);

   // Per-word modular add; carries deliberately never cross word boundaries.
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < WORDS; i++) begin
         sum_d[i*W +: W] = chain_q[i*W +: W] + f[i*W +: W];
      end
   end

   // NOTE: every register below uses <= so all updates see the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         chain_q        <= IV;
         mid_q          <= IV;
         inner_q        <= '0;
         digest_q       <= '0;
         mid_ok_q       <= 1'b0;
         digest_valid_q <= 1'b0;
         sweep_err_q    <= 1'b0;
      end else begin
         sweep_err_q <= 1'b0;
         if (start) begin
            // start wins over sweep, mid_load and any same-cycle transfer
            chain_q        <= IV;
            mid_ok_q       <= 1'b0;
            digest_valid_q <= 1'b0;
            state_q        <= S_B1;
         end else if (sweep && rest_w) begin
            if (mid_ok_q) begin
               // in DONE this discards the held digest
               chain_q        <= mid_q;
               digest_valid_q <= 1'b0;
               state_q        <= S_B2;
            end else begin
               sweep_err_q <= 1'b1;
            end
         end else begin
            if (mid_load_w && rest_w) begin
               mid_q    <= mid_in_w;
               mid_ok_q <= 1'b1;
            end
            unique case (state_q)
               S_IDLE: ;
               S_B1: if (f_valid) begin
                  chain_q  <= sum_d;
                  mid_q    <= sum_d;
                  mid_ok_q <= 1'b1;
                  state_q  <= S_B2;
               end
               S_B2: if (f_valid) begin
                  inner_q <= sum_d;
                  chain_q <= IV;   // second hash starts from IV
                  state_q <= S_B3;
               end
               S_B3: if (f_valid) begin
                  digest_q       <= sum_d;
                  digest_valid_q <= 1'b1;
                  state_q        <= S_DONE;
               end
               S_DONE: if (digest_ready) begin
                  digest_valid_q <= 1'b0;
                  state_q        <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      phase = 2'd0;
      unique case (state_q)
         S_B1:    phase = 2'd1;
         S_B2:    phase = 2'd2;
         S_B3:    phase = 2'd3;
         default: phase = 2'd0;
      endcase
   end

   assign f_ready      = (state_q == S_B1) || (state_q == S_B2) || (state_q == S_B3);
   assign chain        = chain_q;
   assign inner        = inner_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;
   assign mid_ok       = mid_ok_q;
   assign sweep_err    = sweep_err_q;

endmodule
